// File: rtl/fp_mac_pkg.sv
// -----------------------------------------------------------------------------
// fp_mac_pkg
//   Shared definitions for the 16-lane floating-point multiply/sum sequencer:
//   lane geometry, the sequencer state encoding and the tag that travels
//   down the multiply/sum delay line alongside each fired group.
// -----------------------------------------------------------------------------
package fp_mac_pkg;

    // Operand lanes per group; mask and select widths follow from it.
    localparam int LANES       = 16;
    localparam int LANE_SEL_W  = $clog2(LANES);
    localparam int LANE_MASK_W = LANES;

    typedef logic [LANE_SEL_W-1:0]  lane_sel_t;
    typedef logic [LANE_MASK_W-1:0] lane_mask_t;

    // INIT clears the datapath after reset, FILL collects pairs into the
    // operand bank, CLOSE spends one cycle launching the collected group.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CLOSE = 2'd2
    } state_e;

    // Per-group tag carried through the multiply and sum latencies.
    typedef struct packed {
        logic fire;   // a group occupies this slot
        logic first;  // first group of its vector: accumulator restarts
        logic last;   // final group of its vector: result completes
    } tag_t;

    localparam tag_t TAG_IDLE = '{fire: 1'b0, first: 1'b0, last: 1'b0};

    // One-hot lane bit for a lane index.
    function automatic lane_mask_t lane_bit(input lane_sel_t sel);
        lane_mask_t m;
        m      = '0;
        m[sel] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/fp_mac_tag_delay.sv
// -----------------------------------------------------------------------------
// fp_mac_tag_delay
//   Fixed-depth shift register for group tags. It advances every cycle and
//   never stalls. A mid tap marks the arrival of a group at the sum stage;
//   the end tap marks the completion of the accumulated result.
//
// Ports
//   aclk        in   clock
//   aresetn     in   asynchronous active-low clear of every slot
//   i_tag       in   tag entering the line this cycle
//   o_mid_tag   out  tag delayed by MID_TAP cycles
//   o_end_done  out  tag delayed by DEPTH cycles is a vector's last group
//   o_any_fire  out  some slot of the line holds a group
// -----------------------------------------------------------------------------
module fp_mac_tag_delay
    import fp_mac_pkg::*;
#(
    parameter int DEPTH   = 20,
    parameter int MID_TAP = 8
) (
    input  logic aclk,
    input  logic aresetn,
    input  tag_t i_tag,
    output tag_t o_mid_tag,
    output logic o_end_done,
    output logic o_any_fire
);

    // r_line[k] holds the tag that entered k+1 cycles ago.
    tag_t r_line [DEPTH];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            // NOTE: this storage array is reset on purpose: a stale fire bit
            // left behind by a reset would raise a spurious sum enable or
            // result strobe after the reset, so every slot must start empty.
            for (int i = 0; i < DEPTH; i++) begin
                r_line[i] <= TAG_IDLE;
            end
        end else begin
            r_line[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_line[i] <= r_line[i-1];
            end
        end
    end

    assign o_mid_tag  = r_line[MID_TAP-1];
    // Only completion matters at the end: the group is fired and closes its
    // vector.
    assign o_end_done = r_line[DEPTH-1].fire & r_line[DEPTH-1].last;

    always_comb begin
        o_any_fire = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            o_any_fire = o_any_fire | r_line[i].fire;
        end
    end

endmodule

// File: rtl/fp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// fp_mac_sequencer
//   Sequencing controller for the 16-lane floating-point multiply/sum
//   datapath. Operand pairs arrive serially with valid/ready and are written
//   one lane at a time into the operand bank. A group closes after 16 pairs
//   or on the last pair of a vector; the multiplier array is then fired with
//   a lane-valid mask and the group's first/last tag is tracked through the
//   multiply and sum latencies to drive the sum stage and the result strobe.
//
// Ports
//   aclk, aresetn           clock, asynchronous active-low reset
//   s_valid/s_ready         operand pair handshake
//   s_a, s_b                operands (IEEE-754 single)
//   s_last                  pair closes the current vector
//   lane_we, lane_sel       operand bank write strobe and lane index
//   lane_a, lane_b          registered operands for the bank write
//   group_fire, lane_mask   multiplier-array enable and valid-lane mask
//   sum_clk_en              sum-stage enable, one cycle per group
//   acc_first, acc_last     accumulator restart / final-group flags
//   res_valid               vector result ready, one-cycle pulse
//   pipe_clr                datapath pipeline clear during INIT
//   busy                    initialising, group open, or groups in flight
// -----------------------------------------------------------------------------
module fp_mac_sequencer
    import fp_mac_pkg::*;
#(
    parameter int MUL_LAT    = 8,
    parameter int SUM_LAT    = 12,
    parameter int CLR_CYCLES = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_a,
    input  logic [31:0]      s_b,
    input  logic             s_last,
    output logic             lane_we,
    output logic [LANE_SEL_W-1:0]  lane_sel,
    output logic [31:0]      lane_a,
    output logic [31:0]      lane_b,
    output logic             group_fire,
    output logic [LANE_MASK_W-1:0] lane_mask,
    output logic             sum_clk_en,
    output logic             acc_first,
    output logic             acc_last,
    output logic             res_valid,
    output logic             pipe_clr,
    output logic             busy
);

    localparam logic [7:0] CLR_LAST  = 8'(CLR_CYCLES - 1);
    localparam lane_sel_t  LANE_LAST = lane_sel_t'(LANES - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e      r_state;
    state_e      w_state_nxt;
    logic [7:0]  r_clr_cnt;

    lane_sel_t   r_cnt;        // next lane to be written in the open group
    lane_mask_t  r_mask;       // lanes written so far in the open group
    logic        r_vec_open;   // a vector has started and not yet ended
    logic        r_grp_first;  // open group is the first of its vector
    logic        r_cl_first;   // tag captured at the closing accept
    logic        r_cl_last;

    logic        r_lane_we;
    lane_sel_t   r_lane_sel;
    logic [31:0] r_lane_a;
    logic [31:0] r_lane_b;

    tag_t        r_fire_tag;   // tag launched with group_fire
    lane_mask_t  r_lane_mask;

    logic        w_accept;
    logic        w_close;
    logic        w_first;
    tag_t        w_mid_tag;
    logic        w_end_done;
    logic        w_any_fire;

    // -------------------------------------------------------------------------
    // Handshake and group-close decode
    // -------------------------------------------------------------------------
    assign s_ready  = (r_state == ST_FILL);
    assign pipe_clr = (r_state == ST_INIT);
    assign w_accept = s_valid & s_ready;
    // A group closes on its 16th pair or on the vector's last pair; a last
    // pair landing in lane 15 therefore closes exactly one full group.
    assign w_close  = w_accept & ((r_cnt == LANE_LAST) | s_last);
    // The first accept of a group decides whether it starts a vector; later
    // accepts of the same group reuse the captured value.
    assign w_first  = (r_cnt == '0) ? ~r_vec_open : r_grp_first;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_INIT;
        end else begin
            // NOTE: state and datapath registers use non-blocking assignment
            // so every flop samples the pre-edge values of the others.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: the default is assigned before the case so that every path
        // drives w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        unique case (r_state)
            ST_INIT:  if (r_clr_cnt == CLR_LAST) w_state_nxt = ST_FILL;
            ST_FILL:  if (w_close)               w_state_nxt = ST_CLOSE;
            ST_CLOSE:                            w_state_nxt = ST_FILL;
            default:                             w_state_nxt = ST_INIT;
        endcase
    end

    // Clear duration counter; only INIT uses it and INIT is left once per
    // reset, so it simply stops at its terminal value.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_INIT && r_clr_cnt != CLR_LAST) begin
            r_clr_cnt <= r_clr_cnt + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Group assembly, bank write and fire
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt       <= '0;
            r_mask      <= '0;
            r_vec_open  <= 1'b0;
            r_grp_first <= 1'b0;
            r_cl_first  <= 1'b0;
            r_cl_last   <= 1'b0;
            r_lane_we   <= 1'b0;
            r_lane_sel  <= '0;
            r_lane_a    <= '0;
            r_lane_b    <= '0;
            r_fire_tag  <= TAG_IDLE;
            r_lane_mask <= '0;
        end else begin
            r_lane_we <= w_accept;

            if (w_accept) begin
                r_lane_sel  <= r_cnt;
                r_lane_a    <= s_a;
                r_lane_b    <= s_b;
                r_mask      <= r_mask | lane_bit(r_cnt);
                r_cnt       <= r_cnt + lane_sel_t'(1);
                r_vec_open  <= ~s_last;
                r_grp_first <= w_first;
                if (w_close) begin
                    r_cl_first <= w_first;
                    r_cl_last  <= s_last;
                end
            end

            // CLOSE never accepts (s_ready is low), so it owns cnt/mask here.
            if (r_state == ST_CLOSE) begin
                r_fire_tag  <= '{fire: 1'b1, first: r_cl_first, last: r_cl_last};
                r_lane_mask <= r_mask;
                r_cnt       <= '0;
                r_mask      <= '0;
            end else begin
                r_fire_tag  <= TAG_IDLE;
                r_lane_mask <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Multiply/sum latency tracking
    // -------------------------------------------------------------------------
    // The line is fed by the registered fire tag, so tap k lags group_fire
    // by exactly k cycles.
    fp_mac_tag_delay #(
        .DEPTH   (MUL_LAT + SUM_LAT),
        .MID_TAP (MUL_LAT)
    ) u_tag_delay (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .i_tag      (r_fire_tag),
        .o_mid_tag  (w_mid_tag),
        .o_end_done (w_end_done),
        .o_any_fire (w_any_fire)
    );

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign lane_we    = r_lane_we;
    assign lane_sel   = r_lane_sel;
    assign lane_a     = r_lane_a;
    assign lane_b     = r_lane_b;
    assign group_fire = r_fire_tag.fire;
    assign lane_mask  = r_lane_mask;
    assign sum_clk_en = w_mid_tag.fire;
    assign acc_first  = w_mid_tag.fire & w_mid_tag.first;
    assign acc_last   = w_mid_tag.fire & w_mid_tag.last;
    assign res_valid  = w_end_done;
    assign busy       = (r_state != ST_FILL) | (r_mask != '0)
                      | r_fire_tag.fire | w_any_fire;

endmodule

// File: doc/fp_mac_sequencer.md
# fp_mac_sequencer

Sequencing controller for the 16-lane floating-point dual-input multiply/sum datapath. It accepts a serial stream of (A, B) operand pairs with valid/ready and writes them one lane at a time into the 16-lane operand bank. When a group closes, it fires the multiplier array with a lane-valid mask and tracks each fired group through the fixed multiply and sum latencies. From that tracking it drives the sum-stage clock enable, the accumulator first/last flags, and the per-vector result strobe.

## Interface
- `LANES`, 16, operand lanes per group (fixed; the mask and select widths derive from it)
- `MUL_LAT`, 8, cycles from `group_fire` to the sum-stage input
- `SUM_LAT`, 12, cycles from `sum_clk_en` to the accumulated result
- `CLR_CYCLES`, 16, post-reset pipeline clear duration, 1..255
- `aclk`  in  1  clock
- `aresetn`  in  1  reset; one clock, asynchronous active-low reset
- `s_valid`  in  1  operand pair valid
- `s_ready`  out  1  sequencer can accept a pair
- `s_a`  in  32  operand A (IEEE-754 single)
- `s_b`  in  32  operand B
- `s_last`  in  1  pair is the final one of the current vector
- `lane_we`  out  1  operand bank write strobe
- `lane_sel`  out  4  lane index for the write
- `lane_a`  out  32  registered A for the write
- `lane_b`  out  32  registered B for the write
- `group_fire`  out  1  one-cycle multiplier-array clock enable
- `lane_mask`  out  16  lanes holding valid data, valid with `group_fire`; the datapath zeroes the other lanes
- `sum_clk_en`  out  1  sum-stage clock enable, one cycle per group
- `acc_first`  out  1  with `sum_clk_en`: clear the accumulator (first group of vector)
- `acc_last`  out  1  with `sum_clk_en`: final group of vector
- `res_valid`  out  1  one-cycle pulse: the vector result is ready
- `pipe_clr`  out  1  datapath pipeline clear
- `busy`  out  1  not in FILL, a partial group is open, or any group is in flight

## Operation
- **States:** INIT, FILL, CLOSE.
- **INIT:**
  - Entered on reset.
  - `pipe_clr`=1 and `s_ready`=0 for `CLR_CYCLES` cycles, then goes to FILL.
- **FILL:**
  - `s_ready`=1.
  - Each accept (`s_valid` & `s_ready`) registers `lane_we`=1, `lane_sel`=`cnt`, and `lane_a`/`lane_b` in the next cycle, sets `mask[cnt]`, and increments `cnt` (0..15).
  - A group closes on an accept with `cnt`==15 or with `s_last`=1; the state moves to CLOSE.
- **CLOSE (one cycle):**
  - `s_ready`=0.
  - Registers `group_fire`=1 and `lane_mask`=`mask` for the next cycle.
  - Tags the group with `first` = (this is the vector's first group) and `last` = `s_last` of the closing pair.
  - Clears `cnt` and `mask` and returns to FILL.
- **Vector tracking:**
  - A `vec_open` flag sets on the first accept of a vector and clears on an accept with `s_last`.
  - `first` = !`vec_open` at the group's first accept.
- **Full group with `s_last`:** when `s_last` arrives on the 16th pair, exactly one group is fired with `lane_mask`=0xFFFF and `last`=1. No empty extra group is fired.
- **Delay line:** a 3-bit (`fire`, `first`, `last`) shift register of depth `MUL_LAT`+`SUM_LAT`.
  - Tap `MUL_LAT` drives `sum_clk_en`, `acc_first`, and `acc_last`.
  - The final tap drives `res_valid` = `fire` & `last`.
- The delay line advances every cycle and never stalls. Fire and sum events in the same cycle are independent.
- **Reset mid-operation:**
  - All state, the open group, and the delay line are cleared.
  - In-flight results are discarded; no `res_valid` is emitted for them.
  - INIT replays.

## Timing
- **Reset values:** every output is 0 except `pipe_clr`=1 and `busy`=1.
- Write outputs appear 1 cycle after the accept.
- `group_fire` appears 2 cycles after the closing accept.
- `s_ready` is low for exactly 1 cycle after each closing accept.
- `sum_clk_en` = `group_fire` + `MUL_LAT`.
- `res_valid` = `group_fire` + `MUL_LAT` + `SUM_LAT`.
- Peak throughput is 16 pairs per 17 cycles.

## Structure
- **Package `fp_mac_pkg`:**
  - `LANES` constant
  - lane mask and lane select widths
  - state enum (INIT/FILL/CLOSE)
  - delay-line tag struct {`fire`, `first`, `last`}
- **Sub-module `fp_mac_tag_delay`:** parameterised-depth tag shift register with a mid tap and an end tap, asynchronously cleared.

## Test plan
- Reset released with `CLR_CYCLES`=4 → `pipe_clr` high for 4 cycles, `s_ready` rises in cycle 5, `busy` falls.
- 16 gapless pairs, `s_last` on the 16th → `lane_sel` 0..15, one `group_fire` with mask 0xFFFF, `sum_clk_en`+`acc_first`+`acc_last` 8 cycles later, `res_valid` 20 cycles after the fire.
- 37 pairs, last on the 37th → fires with masks 0xFFFF, 0xFFFF, 0x001F; `acc_first` only on group 1, `acc_last` only on group 3; exactly one `res_valid`.
- Two 1-pair vectors back to back → two fires, each with mask 0x0001, `first`=`last`=1; fires 2 cycles apart; two `res_valid` pulses 2 cycles apart.
- Random `s_valid` gaps on a 20-pair vector → identical `lane_sel`/`lane_a` sequence and masks (0xFFFF, 0x000F) as the gapless run.
- `aresetn` asserted after 7 pairs with 2 groups in flight → all outputs at reset values immediately; no `res_valid` after release; INIT replays.
